// File: rtl/first_nios2_system_mul_core_pkg.sv
// Register map, CTRL bit positions and FSM state type shared by the
// multiplier core, its datapath, the driver header and the bench.
package first_nios2_system_mul_core_pkg;

    localparam logic [2:0] ADDR_OPA     = 3'd0;
    localparam logic [2:0] ADDR_OPB     = 3'd1;
    localparam logic [2:0] ADDR_CTRL    = 3'd2;
    localparam logic [2:0] ADDR_PROD_LO = 3'd4;
    localparam logic [2:0] ADDR_PROD_HI = 3'd5;

    // CTRL write bits
    localparam int CTRL_START    = 0;
    localparam int CTRL_SIGNED   = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_CLR_DONE = 3;

    // CTRL read (status) bits
    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_IRQ_EN = 2;
    localparam int STAT_SIGNED = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mul_state_e;

endpackage

// File: rtl/first_nios2_system_mul_core_mul_shift_add_dp.sv
// Radix-2 shift-add datapath: magnitude conversion at load, one
// conditional add plus right shift per step, sign fixup into the
// visible product register.
module first_nios2_system_mul_core_mul_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_fix,
    input  logic [WIDTH-1:0]   i_opa,
    input  logic [WIDTH-1:0]   i_opb,
    input  logic               i_signed,
    output logic [2*WIDTH-1:0] o_prod
);

    logic [WIDTH-1:0]   r_mcand;   // multiplicand magnitude
    logic [WIDTH-1:0]   r_hi;      // upper accumulator
    logic [WIDTH-1:0]   r_lo;      // multiplier, shifted out as product bits come in
    logic               r_neg;     // result must be negated in FIX
    logic [2*WIDTH-1:0] r_prod;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;

    // Unsigned negation of the most negative value yields 2**(WIDTH-1),
    // which still fits in WIDTH bits as a magnitude.
    assign w_mag_a = (i_signed && i_opa[WIDTH-1]) ? -i_opa : i_opa;
    assign w_mag_b = (i_signed && i_opb[WIDTH-1]) ? -i_opb : i_opb;

    // Carry out of the add is kept and shifted into r_hi msb.
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});

    // Accumulator load/step, product publish on fix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_neg   <= 1'b0;
            r_prod  <= '0;
        end else if (i_load) begin
            r_mcand <= w_mag_a;
            r_lo    <= w_mag_b;
            r_hi    <= '0;
            r_neg   <= i_signed & (i_opa[WIDTH-1] ^ i_opb[WIDTH-1]);
        end else if (i_step) begin
            r_hi    <= w_sum[WIDTH:1];
            r_lo    <= {w_sum[0], r_lo[WIDTH-1:1]};
        end else if (i_fix) begin
            r_prod  <= r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
        end
    end

    assign o_prod = r_prod;

endmodule

// File: rtl/first_nios2_system_mul_core.sv
// Avalon-MM slave iterative multiplier: bus decode, control/status
// registers and the IDLE/CALC/FIX sequencer around the shift-add datapath.
module first_nios2_system_mul_core
    import first_nios2_system_mul_core_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    mul_state_e         r_state, w_next;
    logic [WIDTH-1:0]   r_opa, r_opb;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done, r_irq_en, r_signed;
    logic               w_wr, w_ctrl_wr, w_busy;
    logic               w_load, w_step, w_fix;
    logic [2*WIDTH-1:0] w_prod;
    logic [63:0]        w_prod64;

    assign w_wr      = chipselect & ~write_n;
    assign w_ctrl_wr = w_wr && (address == ADDR_CTRL);
    assign w_busy    = (r_state != ST_IDLE);
    assign w_prod64  = 64'(w_prod);
    assign irq       = r_done & r_irq_en;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next state and datapath strobes; START is only honoured in IDLE.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        w_fix  = 1'b0;
        unique case (r_state)
            ST_IDLE: if (w_ctrl_wr && writedata[CTRL_START]) begin
                w_load = 1'b1;
                w_next = ST_CALC;
            end
            ST_CALC: begin
                w_step = 1'b1;
                if (r_cnt == '0) w_next = ST_FIX;
            end
            ST_FIX: begin
                w_fix  = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Iteration counter: WIDTH steps, counting WIDTH-1 down to 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    r_cnt <= '0;
        else if (w_load) r_cnt <= CNT_W'(WIDTH-1);
        else if (w_step) r_cnt <= r_cnt - CNT_W'(1);
    end

    // Operand registers; writes while busy only affect the next start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_opa <= '0;
            r_opb <= '0;
        end else if (w_wr) begin
            if (address == ADDR_OPA) r_opa <= writedata[WIDTH-1:0];
            if (address == ADDR_OPB) r_opb <= writedata[WIDTH-1:0];
        end
    end

    // Control/status: irq_en follows every CTRL write, signed latches on
    // an accepted start, done set by FIX wins over any clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
            r_signed <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_irq_en <= writedata[CTRL_IRQ_EN];
            if (w_load)    r_signed <= writedata[CTRL_SIGNED];
            if (w_fix)                                         r_done <= 1'b1;
            else if (w_load)                                   r_done <= 1'b0;
            else if (w_ctrl_wr && writedata[CTRL_CLR_DONE])    r_done <= 1'b0;
        end
    end

    first_nios2_system_mul_core_mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .rst_n    (reset_n),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_fix    (w_fix),
        .i_opa    (r_opa),
        .i_opb    (r_opb),
        .i_signed (writedata[CTRL_SIGNED]),
        .o_prod   (w_prod)
    );

    // Zero-wait-state read mux; unmapped addresses read 0.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_OPA:     readdata = 32'(r_opa);
            ADDR_OPB:     readdata = 32'(r_opb);
            ADDR_CTRL: begin
                readdata[STAT_BUSY]   = w_busy;
                readdata[STAT_DONE]   = r_done;
                readdata[STAT_IRQ_EN] = r_irq_en;
                readdata[STAT_SIGNED] = r_signed;
            end
            ADDR_PROD_LO: readdata = w_prod64[31:0];
            ADDR_PROD_HI: readdata = w_prod64[63:32];
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_first_nios2_system_mul_core.sv
// Scenario bench for the iterative multiplier; expected products are
// queued at start and popped when the core goes idle.
module tb_first_nios2_system_mul_core;
    import first_nios2_system_mul_core_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [63:0] sb[$];

    first_nios2_system_mul_core #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1 d = readdata;
        chipselect = 1'b0;
    endtask

    // Load operands, queue the reference product, then write CTRL with START.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ctrl);
        logic [63:0] e;
        bus_write(ADDR_OPA, a);
        bus_write(ADDR_OPB, b);
        if (ctrl[CTRL_SIGNED]) e = 64'(longint'($signed(a)) * longint'($signed(b)));
        else                   e = {32'h0, a} * {32'h0, b};
        sb.push_back(e);
        bus_write(ADDR_CTRL, ctrl | 32'h1);
    endtask

    task automatic wait_idle(output logic to);
        logic [31:0] s;
        to = 1'b1;
        for (int n = 0; n < 200; n++) begin
            bus_read(ADDR_CTRL, s);
            if (!s[STAT_BUSY]) begin to = 1'b0; break; end
        end
    endtask

    task automatic read_prod(output logic [63:0] p);
        logic [31:0] lo, hi;
        bus_read(ADDR_PROD_LO, lo);
        bus_read(ADDR_PROD_HI, hi);
        p = {hi, lo};
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [2:0]  addrs [6];
        addrs = '{ADDR_OPA, ADDR_OPB, ADDR_CTRL, ADDR_PROD_LO, ADDR_PROD_HI, 3'd3};
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        foreach (addrs[i]) begin
            bus_read(addrs[i], d);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL reset_reg%0d: got %h want 0", addrs[i], d); end
        end
        bus_write(3'd3, 32'hDEADBEEF);
        bus_write(3'd7, 32'h12345678);
        bus_read(3'd3, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped3: got %h want 0", d); end
        bus_read(3'd7, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped7: got %h want 0", d); end
    endtask

    task automatic test_unsigned;
        logic to; int c0, c1; logic [63:0] p, e; logic [31:0] s;
        logic [31:0] opa [2], opb [2];
        opa = '{32'd7, 32'hFFFFFFFF};
        opb = '{32'd6, 32'hFFFFFFFF};
        foreach (opa[i]) begin
            start_op(opa[i], opb[i], 32'h0);
            c0 = cyc;
            wait_idle(to);
            c1 = cyc;
            checks++; if (to) begin errors++; $display("FAIL uns_timeout%0d: still busy want idle", i); end
            checks++; if (c1 - c0 !== 33) begin errors++; $display("FAIL uns_latency%0d: got %0d want 33", i, c1 - c0); end
            e = sb.pop_front();
            read_prod(p);
            checks++; if (p !== e) begin errors++; $display("FAIL uns_prod%0d: got %h want %h", i, p, e); end
            bus_read(ADDR_CTRL, s);
            checks++; if (s !== 32'h2) begin errors++; $display("FAIL uns_status%0d: got %h want 2", i, s); end
        end
    endtask

    task automatic test_signed;
        logic to; logic [63:0] p, e; logic [31:0] s;
        logic [31:0] opa [4], opb [4];
        opa = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9, 32'h80000000};
        opb = '{32'd5,        32'h80000000, 32'hFFFFFFF7, 32'd1};
        foreach (opa[i]) begin
            start_op(opa[i], opb[i], 32'h2);
            wait_idle(to);
            checks++; if (to) begin errors++; $display("FAIL sgn_timeout%0d: still busy want idle", i); end
            e = sb.pop_front();
            read_prod(p);
            checks++; if (p !== e) begin errors++; $display("FAIL sgn_prod%0d: got %h want %h", i, p, e); end
            bus_read(ADDR_CTRL, s);
            checks++; if (s !== 32'hA) begin errors++; $display("FAIL sgn_status%0d: got %h want a", i, s); end
        end
    endtask

    task automatic test_start_while_busy;
        logic to; int c0, c1; logic [63:0] p, e; logic [31:0] d;
        start_op(32'd2, 32'd3, 32'h0);
        c0 = cyc;
        repeat (8) @(negedge clk);
        bus_write(ADDR_OPA, 32'd9);
        bus_write(ADDR_CTRL, 32'h3);
        wait_idle(to);
        c1 = cyc;
        checks++; if (to) begin errors++; $display("FAIL swb_timeout: still busy want idle"); end
        checks++; if (c1 - c0 !== 33) begin errors++; $display("FAIL swb_latency: got %0d want 33", c1 - c0); end
        e = sb.pop_front();
        read_prod(p);
        checks++; if (p !== e) begin errors++; $display("FAIL swb_prod: got %h want %h", p, e); end
        bus_read(ADDR_OPA, d);
        checks++; if (d !== 32'd9) begin errors++; $display("FAIL swb_opa: got %h want 9", d); end
        bus_read(ADDR_CTRL, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL swb_status: got %h want 2", d); end
    endtask

    task automatic test_irq;
        logic to; logic [63:0] p, e; logic [31:0] s;
        bus_write(ADDR_CTRL, 32'h4);
        start_op(32'd4, 32'd4, 32'h4);
        bus_read(ADDR_CTRL, s);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_busy: got %b want 0", irq); end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL irq_timeout: still busy want idle"); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_done: got %b want 1", irq); end
        bus_read(ADDR_CTRL, s);
        checks++; if (s !== 32'h6) begin errors++; $display("FAIL irq_status: got %h want 6", s); end
        e = sb.pop_front();
        bus_write(ADDR_CTRL, 32'hC);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr: got %b want 0", irq); end
        read_prod(p);
        checks++; if (p !== e) begin errors++; $display("FAIL irq_prod: got %h want %h", p, e); end
    endtask

    task automatic test_done_collisions;
        logic to; logic [63:0] p, e; logic [31:0] s;
        // CLR_DONE lands on the FIX edge: set must win.
        start_op(32'd3, 32'd3, 32'h0);
        repeat (32) @(negedge clk);
        bus_write(ADDR_CTRL, 32'h8);
        bus_read(ADDR_CTRL, s);
        checks++; if (s !== 32'h2) begin errors++; $display("FAIL clr_vs_fix: got %h want 2", s); end
        e = sb.pop_front();
        read_prod(p);
        checks++; if (p !== e) begin errors++; $display("FAIL clr_vs_fix_prod: got %h want %h", p, e); end
        // START + CLR_DONE in IDLE: runs, done cleared.
        sb.push_back(64'd9);
        bus_write(ADDR_CTRL, 32'h9);
        bus_read(ADDR_CTRL, s);
        checks++; if (s !== 32'h1) begin errors++; $display("FAIL start_clr_status: got %h want 1", s); end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL start_clr_timeout: still busy want idle"); end
        e = sb.pop_front();
        read_prod(p);
        checks++; if (p !== e) begin errors++; $display("FAIL start_clr_prod: got %h want %h", p, e); end
    endtask

    task automatic test_reset_mid;
        logic to; logic [63:0] p, e;
        bus_write(ADDR_CTRL, 32'h4);
        start_op(32'd100, 32'd200, 32'h4);
        repeat (11) @(negedge clk);
        #2 reset_n = 1'b0;
        void'(sb.pop_front());
        address = ADDR_CTRL; chipselect = 1'b1; write_n = 1'b1;
        #1;
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rmid_status: got %h want 0", readdata); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rmid_irq: got %b want 0", irq); end
        address = ADDR_PROD_LO;
        #1;
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rmid_prodlo: got %h want 0", readdata); end
        address = ADDR_PROD_HI;
        #1;
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL rmid_prodhi: got %h want 0", readdata); end
        chipselect = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        start_op(32'd5, 32'd9, 32'h0);
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL rmid_timeout: still busy want idle"); end
        e = sb.pop_front();
        read_prod(p);
        checks++; if (p !== e) begin errors++; $display("FAIL rmid_prod: got %h want %h", p, e); end
    endtask

    initial begin
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset;
        test_unsigned;
        test_signed;
        test_start_while_busy;
        test_irq;
        test_done_collisions;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

endmodule
